// File: rtl/uart_tx_fifo.sv
// Buffered UART transmit front-end: IO-bus byte FIFO draining into uart_tx via DV/Active/Done.
// Optional registered low-watermark interrupt built when UART_TX_FIFO_IRQ_EN is defined.
module uart_tx_fifo #(
  parameter int unsigned DEPTH         = 16,
  parameter logic [31:0] BASE_ADDR     = 32'h4000_0000,
  parameter int unsigned IRQ_THRESHOLD = 2
) (
  input  logic        clock,
  input  logic        resetActiveLow,
  input  logic        ioWriteValid,
  input  logic [31:0] ioWriteAddress,
  input  logic [31:0] ioWriteData,
  input  logic [31:0] ioReadAddress,
  output logic [31:0] ioReadData,
  output logic        txDataValid,
  output logic [7:0]  txByte,
  input  logic        txActive,
  input  logic        txDone,
  output logic        fifoFull,
  output logic        fifoEmpty,
  output logic        txIrq
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {StIdle, StLoad, StWaitStart, StWaitDone} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            irq_en_q, irq_en_d;
  logic [7:0]      tx_byte_q;
  logic [7:0]      mem_q [DEPTH];

  logic            push_req, push, pop, ctrl_wr, flush;
  logic            unused_wdata;

  assign unused_wdata = ^ioWriteData[31:8];

  assign fifoFull  = (count_q == CW'(DEPTH));
  assign fifoEmpty = (count_q == '0);

  assign push_req = ioWriteValid && (ioWriteAddress == BASE_ADDR);
  assign push     = push_req && !fifoFull;
  assign ctrl_wr  = ioWriteValid && (ioWriteAddress == BASE_ADDR + 32'd8);
  assign flush    = ctrl_wr && ioWriteData[0];

  assign txDataValid = (state_q == StLoad);
  assign txByte      = tx_byte_q;

  // A flush suppresses the pop, so the FSM simply stays in idle that cycle.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      StIdle: begin
        if (!fifoEmpty && !txActive && !flush) begin
          pop     = 1'b1;
          state_d = StLoad;
        end
      end
      StLoad:      state_d = StWaitStart;
      StWaitStart: if (txActive || txDone) state_d = StWaitDone;
      StWaitDone:  if (txDone || !txActive) state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    irq_en_d   = irq_en_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
    // Fullness is judged on the registered count, so a same-cycle pop does not rescue a push.
    if (push_req && fifoFull)       overflow_d = 1'b1;
    if (ctrl_wr && ioWriteData[1])  overflow_d = 1'b0;
    if (ctrl_wr)                    irq_en_d   = ioWriteData[2];
  end

  always_ff @(posedge clock or negedge resetActiveLow) begin
    if (!resetActiveLow) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      irq_en_q   <= 1'b0;
      tx_byte_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      irq_en_q   <= irq_en_d;
      if (pop) tx_byte_q <= mem_q[rd_ptr_q];
    end
  end

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= ioWriteData[7:0];
  end

  always_comb begin
    ioReadData = '0;
    if (ioReadAddress == BASE_ADDR + 32'd4) begin
      ioReadData[0]    = fifoFull;
      ioReadData[1]    = fifoEmpty;
      ioReadData[2]    = txActive;
      ioReadData[3]    = overflow_q;
      ioReadData[4]    = (state_q != StIdle);
      ioReadData[15:8] = 8'(count_q);
    end else if (ioReadAddress == BASE_ADDR + 32'd8) begin
      ioReadData[2] = irq_en_q;
    end
  end

`ifdef UART_TX_FIFO_IRQ_EN
  logic irq_q;
  always_ff @(posedge clock or negedge resetActiveLow) begin
    if (!resetActiveLow) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_en_q && (32'(count_q) <= IRQ_THRESHOLD) && !overflow_q;
    end
  end
  assign txIrq = irq_q;
`else
  assign txIrq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a small behavioural uart_tx model.
module tb_uart_tx_fifo;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] STAT = 32'h4000_0004;
  localparam logic [31:0] CTRL = 32'h4000_0008;
`ifdef UART_TX_FIFO_IRQ_EN
  localparam logic EXP_IRQ = 1'b1;
`else
  localparam logic EXP_IRQ = 1'b0;
`endif

  logic        clock, resetActiveLow;
  logic        ioWriteValid;
  logic [31:0] ioWriteAddress, ioWriteData, ioReadAddress, ioReadData;
  logic        txDataValid, txActive, txDone, fifoFull, fifoEmpty, txIrq;
  logic [7:0]  txByte;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // uart_tx model: 4-cycle frames; hold forces Active high to stall draining.
  logic        act_q, done_q, hold;
  int unsigned frm_q;
  logic [7:0]  drained [$];

  assign txActive = act_q | hold;
  assign txDone   = done_q;

  uart_tx_fifo dut (
    .clock          (clock),
    .resetActiveLow (resetActiveLow),
    .ioWriteValid   (ioWriteValid),
    .ioWriteAddress (ioWriteAddress),
    .ioWriteData    (ioWriteData),
    .ioReadAddress  (ioReadAddress),
    .ioReadData     (ioReadData),
    .txDataValid    (txDataValid),
    .txByte         (txByte),
    .txActive       (txActive),
    .txDone         (txDone),
    .fifoFull       (fifoFull),
    .fifoEmpty      (fifoEmpty),
    .txIrq          (txIrq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock or negedge resetActiveLow) begin
    if (!resetActiveLow) begin
      act_q  <= 1'b0;
      done_q <= 1'b0;
      frm_q  <= 0;
    end else begin
      done_q <= 1'b0;
      if (txDataValid) begin
        act_q <= 1'b1;
        frm_q <= 4;
        drained.push_back(txByte);
      end else if (act_q) begin
        if (frm_q > 1) begin
          frm_q <= frm_q - 1;
        end else begin
          act_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // All tasks enter and leave on a falling clock edge.
  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    ioWriteValid   = 1'b1;
    ioWriteAddress = addr;
    ioWriteData    = data;
    @(negedge clock);
    ioWriteValid   = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] data);
    ioReadAddress = addr;
    #1;
    data = ioReadData;
  endtask

  task automatic wait_idle();
    logic [31:0] st;
    logic        ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      rd(STAT, st);
      if (!txActive && fifoEmpty && !st[4]) begin
        ok = 1'b0 | 1'b1;
        break;
      end
      @(negedge clock);
    end
    check("drain_done", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_active();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (txActive) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    check("active_seen", {31'd0, ok}, 32'd1);
  endtask

  logic [31:0] st;
  logic        found;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    resetActiveLow = 1'b0;
    ioWriteValid   = 1'b0;
    ioWriteAddress = '0;
    ioWriteData    = '0;
    ioReadAddress  = '0;
    hold           = 1'b0;
    repeat (3) @(negedge clock);
    resetActiveLow = 1'b1;
    @(negedge clock);

    // Reset state and ignored addresses
    check("rst_dv",    {31'd0, txDataValid}, 32'd0);
    check("rst_empty", {31'd0, fifoEmpty},   32'd1);
    check("rst_full",  {31'd0, fifoFull},    32'd0);
    check("rst_irq",   {31'd0, txIrq},       32'd0);
    check("rst_byte",  {24'd0, txByte},      32'd0);
    rd(STAT, st);
    check("rst_status", st, 32'h0000_0002);
    wr(32'h4000_0010, 32'h55);
    wr(STAT, 32'h66);
    repeat (4) @(negedge clock);
    rd(STAT, st);
    check("alias_status", st, 32'h0000_0002);
    check("alias_nodrain", drained.size(), 32'd0);

    // Single byte latency
    wr(BASE, 32'h41);
    check("lat_dv0", {31'd0, txDataValid}, 32'd0);
    @(negedge clock);
    check("lat_dv1",  {31'd0, txDataValid}, 32'd1);
    check("lat_byte", {24'd0, txByte},      32'h41);
    rd(STAT, st);
    check("lat_status", st, 32'h0000_0012);
    @(negedge clock);
    check("lat_pulse_end", {31'd0, txDataValid}, 32'd0);
    wait_idle();
    check("lat_count", drained.size(), 32'd1);

    // Burst fill, overflow, and full push colliding with a pop
    drained.delete();
    hold = 1'b1;
    for (int i = 0; i < 16; i++) wr(BASE, 32'(i));
    rd(STAT, st);
    check("full_status", st, 32'h0000_1005);
    check("full_flag", {31'd0, fifoFull}, 32'd1);
    wr(BASE, 32'hFF);
    rd(STAT, st);
    check("ovf_status", st, 32'h0000_100D);
    wr(CTRL, 32'h2);
    rd(STAT, st);
    check("ovf_clear", st, 32'h0000_1005);
    hold = 1'b0;
    wr(BASE, 32'hFF);
    rd(STAT, st);
    check("pushpop_status", st, 32'h0000_0F18);
    wait_idle();
    check("burst_len", drained.size(), 32'd16);
    for (int i = 0; i < 16; i++) begin
      if (i < drained.size()) check("burst_byte", {24'd0, drained[i]}, 32'(i));
    end
    rd(STAT, st);
    check("burst_end_status", st, 32'h0000_000A);

    // Flush mid-burst keeps the in-flight byte and the sticky overflow
    drained.delete();
    hold = 1'b1;
    for (int i = 0; i < 5; i++) wr(BASE, 32'h20 + 32'(i));
    hold = 1'b0;
    @(negedge clock);
    wait_active();
    wr(CTRL, 32'h1);
    rd(STAT, st);
    check("flush_status", st, 32'h0000_001E);
    wr(CTRL, 32'h2);
    rd(STAT, st);
    check("flush_ovf_clr", st, 32'h0000_0016);
    wait_idle();
    repeat (20) @(negedge clock);
    check("flush_len",  drained.size(), 32'd1);
    if (drained.size() > 0) check("flush_byte", {24'd0, drained[0]}, 32'h20);
    rd(STAT, st);
    check("flush_end_status", st, 32'h0000_0002);

    // Low-watermark interrupt
    hold = 1'b1;
    for (int i = 0; i < 5; i++) wr(BASE, 32'h30 + 32'(i));
    wr(CTRL, 32'h4);
    repeat (2) @(negedge clock);
    check("irq_high_count", {31'd0, txIrq}, 32'd0);
    rd(CTRL, st);
    check("ctrl_readback", st, 32'h0000_0004);
    hold  = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      rd(STAT, st);
      if (st[15:8] == 8'd2) begin
        found = 1'b1;
        break;
      end
      @(negedge clock);
    end
    check("irq_count2_seen", {31'd0, found}, 32'd1);
    check("irq_lag", {31'd0, txIrq}, 32'd0);
    @(negedge clock);
    check("irq_low_count", {31'd0, txIrq}, {31'd0, EXP_IRQ});
    wait_idle();

    // Asynchronous reset while waiting for done
    wr(BASE, 32'h50);
    wait_active();
    @(negedge clock);
    resetActiveLow = 1'b0;
    #1;
    check("arst_dv",    {31'd0, txDataValid}, 32'd0);
    check("arst_empty", {31'd0, fifoEmpty},   32'd1);
    check("arst_irq",   {31'd0, txIrq},       32'd0);
    rd(STAT, st);
    check("arst_status", st, 32'h0000_0002);
    rd(CTRL, st);
    check("arst_ctrl", st, 32'h0000_0000);
    @(negedge clock);
    resetActiveLow = 1'b1;
    repeat (3) @(negedge clock);
    rd(STAT, st);
    check("post_rst_status", st, 32'h0000_0002);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
